// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch sequencer.
//   state_t     : sequencer FSM states (IDLE, RUN, DONE)
//   br_cond_t   : branch-condition encoding carried on br_cond
//   br_taken()  : evaluates a branch condition against the registered flags
//   CNT_W/CNT_MAX : width and saturation value of the RUN-cycle counter
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_Z      = 2'b01,
    BR_NZ     = 2'b10,
    BR_PAR    = 2'b11
  } br_cond_t;

  localparam int          CNT_W   = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic br_taken(input br_cond_t cond,
                                    input logic     zero_q,
                                    input logic     pari_q);
    logic t;
    case (cond)
      BR_ALWAYS: t = 1'b1;
      BR_Z:      t = zero_q;
      BR_NZ:     t = ~zero_q;
      BR_PAR:    t = pari_q;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_seq_jump_lut.sv
// jump_lut: runtime-writable jump-target table, 2**LW entries of D bits.
//   clk, reset      : clock, async active-high reset (clears every entry)
//   we/waddr/wdata  : synchronous write port
//   raddr/rdata     : combinational read port; a same-cycle write to the
//                     read index is seen only after the edge
module jump_lut #(
  parameter int D  = 12,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [LW-1:0] waddr,
  input  logic [D-1:0]  wdata,
  input  logic [LW-1:0] raddr,
  output logic [D-1:0]  rdata
);

  localparam int N = 2**LW;

  logic [D-1:0] mem [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer driving prog_ctr into instr_ROM.
//   clk, reset           : clock, async active-high reset (forces IDLE)
//   req, start_addr      : start handshake and entry PC (accepted in IDLE/DONE)
//   stall                : hold PC this cycle
//   halt                 : current instruction is a halt -> DONE
//   br_en, br_cond, br_abs, lut_idx : branch request, condition, mode, table index
//   zero_q, pari_q       : registered flags for conditional branches
//   lut_we, lut_waddr, lut_wdata    : jump-table write port
//   prog_ctr             : current instruction address
//   run, done            : state decode (RUN / DONE level)
//   oob                  : sticky PC-overflow flag, cleared on next start
//   cycle_cnt            : RUN-cycle count, saturating
// Optional build macro FETCH_CYCLE_CNT_EN: builds the RUN-cycle counter;
// without it cycle_cnt is tied to zero.
//
// state | meaning
// IDLE  | waiting for req after reset
// RUN   | fetching; PC advances, branches or holds each edge
// DONE  | stopped by halt or PC overflow; PC frozen, waiting for req
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int D  = 12,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt,
  input  logic          br_en,
  input  logic [1:0]    br_cond,
  input  logic          br_abs,
  input  logic [LW-1:0] lut_idx,
  input  logic          zero_q,
  input  logic          pari_q,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic          run,
  output logic          done,
  output logic          oob,
  output logic [15:0]   cycle_cnt
);

  localparam logic [D-1:0] PC_ONE = D'(1);

  state_t       state, state_nxt;
  logic [D-1:0] pc_nxt;
  logic         oob_nxt;
  logic [D-1:0] lut_rdata;

  jump_lut #(.D(D), .LW(LW)) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (lut_idx),
    .rdata (lut_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      oob      <= 1'b0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      oob      <= oob_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    oob_nxt   = oob;
    case (state)
      IDLE, DONE: begin
        if (req) begin
          state_nxt = RUN;
          pc_nxt    = start_addr;
          oob_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_nxt = DONE;
          end else if (br_en && br_taken(br_cond_t'(br_cond), zero_q, pari_q)) begin
            // relative targets wrap mod 2**D by design; no overflow flag
            pc_nxt = br_abs ? lut_rdata : prog_ctr + lut_rdata;
          end else if (&prog_ctr) begin
            state_nxt = DONE;
            oob_nxt   = 1'b1;
          end else begin
            pc_nxt = prog_ctr + PC_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign run  = (state == RUN);
  assign done = (state == DONE);

`ifdef FETCH_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state != RUN && req) begin
      cnt <= '0;
    end else if (state == RUN && cnt != CNT_MAX) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign cycle_cnt = cnt;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  localparam int D  = 12;
  localparam int LW = 5;
`ifdef FETCH_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [D-1:0]  start_addr;
  logic          stall, halt, br_en, br_abs, zero_q, pari_q, lut_we;
  logic [1:0]    br_cond;
  logic [LW-1:0] lut_idx, lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic [D-1:0]  prog_ctr;
  logic          run, done, oob;
  logic [15:0]   cycle_cnt;

  always #5 clk = ~clk;

  fetch_seq #(.D(D), .LW(LW)) dut (
    .clk(clk), .reset(reset), .req(req), .start_addr(start_addr),
    .stall(stall), .halt(halt), .br_en(br_en), .br_cond(br_cond),
    .br_abs(br_abs), .lut_idx(lut_idx), .zero_q(zero_q), .pari_q(pari_q),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .run(run), .done(done), .oob(oob),
    .cycle_cnt(cycle_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain arithmetic over the start/branch/halt rules.
  int m_pc, m_cnt;
  bit m_run, m_done, m_oob;
  int m_lut [32];

  typedef struct {
    logic          req;
    logic [D-1:0]  sa;
    logic          stall, halt, br;
    logic [1:0]    cond;
    logic          abs;
    logic [LW-1:0] idx;
    logic          zq, pq, we;
    logic [LW-1:0] wa;
    logic [D-1:0]  wd;
    logic [D-1:0]  pc;
    logic          run, done, oob;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [D-1:0] sa, logic st, logic h, logic br,
                              logic [1:0] cond, logic ab, logic [LW-1:0] idx,
                              logic zq, logic pq, logic we, logic [LW-1:0] wa,
                              logic [D-1:0] wd, logic [D-1:0] pc, logic ru,
                              logic dn, logic ob);
    vec_t v;
    v.req = r; v.sa = sa; v.stall = st; v.halt = h; v.br = br; v.cond = cond;
    v.abs = ab; v.idx = idx; v.zq = zq; v.pq = pq; v.we = we; v.wa = wa; v.wd = wd;
    v.pc = pc; v.run = ru; v.done = dn; v.oob = ob;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req = 0; start_addr = '0; stall = 0; halt = 0; br_en = 0; br_cond = 2'b00;
    br_abs = 0; lut_idx = '0; zero_q = 0; pari_q = 0; lut_we = 0;
    lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_oob = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
  endtask

  task automatic model_step();
    bit taken;
    int tgt;
    tgt = m_lut[lut_idx];
    if (m_run) begin
      if (m_cnt < 65535) m_cnt++;
      if (!stall) begin
        if (halt) begin
          m_run = 0; m_done = 1;
        end else begin
          case (br_cond)
            2'b00:   taken = 1'b1;
            2'b01:   taken = zero_q;
            2'b10:   taken = !zero_q;
            default: taken = pari_q;
          endcase
          taken = taken && br_en;
          if (taken) m_pc = br_abs ? tgt : (m_pc + tgt) % 4096;
          else if (m_pc == 4095) begin m_run = 0; m_done = 1; m_oob = 1; end
          else m_pc = m_pc + 1;
        end
      end
    end else if (req) begin
      m_run = 1; m_done = 0; m_pc = int'(start_addr); m_oob = 0; m_cnt = 0;
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pc"},   32'(prog_ctr),  32'(m_pc));
    chk({tag, "_run"},  32'(run),       32'(m_run));
    chk({tag, "_done"}, 32'(done),      32'(m_done));
    chk({tag, "_oob"},  32'(oob),       32'(m_oob));
    chk({tag, "_cnt"},  32'(cycle_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    check_model("reset");
    #12;
    reset = 1'b0;

    //          req sa      st h  br cond  ab idx zq pq we wa wd       pc      run dn oob
    tbl.push_back(mk(1, 12'h010, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h010, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h011, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h012, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h013, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h014, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h014, 0, 1, 0));
    tbl.push_back(mk(1, 12'h012, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3, 12'h200, 12'h012, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b00, 1, 3, 0, 0, 0, 0, 12'h000, 12'h200, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h200, 0, 1, 0));
    tbl.push_back(mk(1, 12'h012, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h012, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b01, 1, 3, 0, 0, 0, 0, 12'h000, 12'h013, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4, 12'hFFE, 12'h014, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h015, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b00, 0, 4, 0, 0, 0, 0, 12'h000, 12'h013, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h014, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h015, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b00, 0, 4, 0, 0, 1, 4, 12'h002, 12'h013, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b00, 0, 4, 0, 0, 0, 0, 12'h000, 12'h015, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h015, 0, 1, 0));
    tbl.push_back(mk(1, 12'h020, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h020, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h020, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h020, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h020, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h020, 0, 1, 0));
    tbl.push_back(mk(1, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 0));
    tbl.push_back(mk(1, 12'hFFE, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFE, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFF, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 1));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 1));
    tbl.push_back(mk(1, 12'h100, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h100, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b11, 1, 3, 0, 1, 0, 0, 12'h000, 12'h200, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b11, 1, 3, 0, 0, 0, 0, 12'h000, 12'h201, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b10, 1, 3, 0, 0, 0, 0, 12'h000, 12'h200, 1, 0, 0));
    tbl.push_back(mk(1, 12'h555, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 12'h000, 12'h201, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 5, 12'hF00, 12'h202, 1, 0, 0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 2'b00, 0, 5, 0, 0, 0, 0, 12'h000, 12'h102, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; start_addr = tbl[i].sa; stall = tbl[i].stall;
      halt = tbl[i].halt; br_en = tbl[i].br; br_cond = tbl[i].cond;
      br_abs = tbl[i].abs; lut_idx = tbl[i].idx; zero_q = tbl[i].zq;
      pari_q = tbl[i].pq; lut_we = tbl[i].we; lut_waddr = tbl[i].wa;
      lut_wdata = tbl[i].wd;
      tick("tblm");
      chk($sformatf("tbl%0d_pc", i),   32'(prog_ctr), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_run", i),  32'(run),      32'(tbl[i].run));
      chk($sformatf("tbl%0d_done", i), 32'(done),     32'(tbl[i].done));
      chk($sformatf("tbl%0d_oob", i),  32'(oob),      32'(tbl[i].oob));
    end

    // mid-run async reset at PC 123, then confirm the table was cleared
    idle_inputs();
    halt = 1; tick("h6");
    idle_inputs(); req = 1; start_addr = 12'h123; tick("s6");
    idle_inputs();
    chk("pc_123", 32'(prog_ctr), 32'h123);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_pc",   32'(prog_ctr), 32'h0);
    chk("rst_run",  32'(run),      32'h0);
    chk("rst_done", 32'(done),     32'h0);
    check_model("rst");
    #2 reset = 1'b0;
    req = 1; start_addr = 12'h050; tick("s6b");
    idle_inputs(); br_en = 1; br_abs = 1; lut_idx = 3; tick("br6");
    chk("lut3_cleared", 32'(prog_ctr), 32'h0);

    // RUN-cycle counter: 10 RUN cycles (2 stalled) plus the halt cycle
    idle_inputs(); halt = 1; tick("h7");
    idle_inputs(); req = 1; start_addr = 12'h000; tick("s7");
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      stall = (k == 3 || k == 6);
      tick("c7");
    end
    stall = 0; halt = 1; tick("h7b");
    idle_inputs();
    chk("cnt_halt", 32'(cycle_cnt), CNT_EN ? 32'd11 : 32'd0);
    chk("pc_halt7", 32'(prog_ctr), 32'h8);
    tick("d7"); tick("d7b");
    chk("cnt_held", 32'(cycle_cnt), CNT_EN ? 32'd11 : 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      req        = ($urandom_range(7) == 0);
      start_addr = ($urandom_range(1) == 0) ? D'($urandom_range(4095, 4080))
                                            : D'($urandom);
      stall      = ($urandom_range(3) == 0);
      halt       = ($urandom_range(15) == 0);
      br_en      = ($urandom_range(3) == 0);
      br_cond    = 2'($urandom);
      br_abs     = 1'($urandom);
      lut_idx    = LW'($urandom);
      zero_q     = 1'($urandom);
      pari_q     = 1'($urandom);
      lut_we     = ($urandom_range(3) == 0);
      lut_waddr  = LW'($urandom);
      lut_wdata  = D'($urandom);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
